mem_arbiter: RTL

Shares one downstream memory port between `PORTS` upstream requesters. It is the counterpart of the id-based memory splitter. Requests are granted round-robin through a registered output stage, and the port index is prepended to the request id. Read responses are steered back to the issuing requester by the id's upper bits. Per-port outstanding-read credit counters stop any one requester from flooding the shared memory.

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between PORTS requesters.
// The port index is prepended to the request id, and responses are steered back by it.
module mem_arbiter #(
    parameter int PORTS           = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WE_WIDTH        = DATA_WIDTH / 8,
    localparam int SEL_WIDTH      = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1),
    localparam int OUT_ID_WIDTH   = ID_WIDTH + SEL_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic [PORTS-1:0]                    req_in_valid,
    output logic [PORTS-1:0]                    req_in_ready,
    input  logic [PORTS-1:0]                    req_in_read_enable,
    input  logic [PORTS-1:0][WE_WIDTH-1:0]      req_in_write_enable,
    input  logic [PORTS-1:0][ADDR_WIDTH-1:0]    req_in_addr,
    input  logic [PORTS-1:0][DATA_WIDTH-1:0]    req_in_data,
    input  logic [PORTS-1:0][ID_WIDTH-1:0]      req_in_id,

    output logic [PORTS-1:0]                    rsp_out_valid,
    input  logic [PORTS-1:0]                    rsp_out_ready,
    output logic [PORTS-1:0]                    rsp_out_read_enable,
    output logic [PORTS-1:0][WE_WIDTH-1:0]      rsp_out_write_enable,
    output logic [PORTS-1:0][ADDR_WIDTH-1:0]    rsp_out_addr,
    output logic [PORTS-1:0][DATA_WIDTH-1:0]    rsp_out_data,
    output logic [PORTS-1:0][ID_WIDTH-1:0]      rsp_out_id,

    output logic                                req_out_valid,
    input  logic                                req_out_ready,
    output logic                                req_out_read_enable,
    output logic [WE_WIDTH-1:0]                 req_out_write_enable,
    output logic [ADDR_WIDTH-1:0]               req_out_addr,
    output logic [DATA_WIDTH-1:0]               req_out_data,
    output logic [OUT_ID_WIDTH-1:0]             req_out_id,

    input  logic                                rsp_in_valid,
    output logic                                rsp_in_ready,
    input  logic                                rsp_in_read_enable,
    input  logic [WE_WIDTH-1:0]                 rsp_in_write_enable,
    input  logic [ADDR_WIDTH-1:0]               rsp_in_addr,
    input  logic [DATA_WIDTH-1:0]               rsp_in_data,
    input  logic [OUT_ID_WIDTH-1:0]             rsp_in_id,

    output logic                                idle
);

    if (PORTS < 1) begin : g_bad_ports
        $error("mem_arbiter: PORTS must be at least 1");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
        $error("mem_arbiter: MAX_OUTSTANDING must be at least 1");
    end

    logic [CNT_WIDTH-1:0]  cnt [PORTS];
    logic [SEL_WIDTH-1:0]  rr_ptr;
    logic [PORTS-1:0]      eligible;
    logic [PORTS-1:0]      gnt;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic                  any_gnt;
    logic                  can_load;
    logic                  sel_re;
    logic [WE_WIDTH-1:0]   sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [SEL_WIDTH-1:0]  rsp_sel;
    logic                  rsp_hit;

    assign can_load = !req_out_valid || req_out_ready;

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            eligible[p] = req_in_valid[p] &&
                          (!req_in_read_enable[p] || cnt[p] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    // First pass finds the first eligible port at or above rr_ptr; the second pass
    // covers the wrap by taking the lowest eligible port overall.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        any_gnt  = 1'b0;
        sel_re   = 1'b0;
        sel_we   = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_id   = '0;
        if (!rst && can_load) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int p = 0; p < PORTS; p++) begin
                    if (!any_gnt && eligible[p] && (pass == 1 || SEL_WIDTH'(p) >= rr_ptr)) begin
                        any_gnt  = 1'b1;
                        gnt[p]   = 1'b1;
                        gnt_idx  = SEL_WIDTH'(p);
                        sel_re   = req_in_read_enable[p];
                        sel_we   = req_in_write_enable[p];
                        sel_addr = req_in_addr[p];
                        sel_data = req_in_data[p];
                        sel_id   = req_in_id[p];
                    end
                end
            end
        end
    end

    assign req_in_ready = gnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_out_valid <= 1'b0;
            rr_ptr        <= '0;
        end else begin
            if (can_load) begin
                req_out_valid <= any_gnt;
            end
            if (any_gnt) begin
                rr_ptr <= (gnt_idx == SEL_WIDTH'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // NOTE: the payload register has no reset; it is only observed while req_out_valid is set.
    always_ff @(posedge clk) begin
        if (any_gnt) begin
            req_out_read_enable  <= sel_re;
            req_out_write_enable <= sel_we;
            req_out_addr         <= sel_addr;
            req_out_data         <= sel_data;
            req_out_id           <= {gnt_idx, sel_id};
        end
    end

    assign rsp_sel = rsp_in_id[ID_WIDTH +: SEL_WIDTH];

    always_comb begin
        rsp_in_ready = 1'b1;
        rsp_hit      = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            rsp_out_valid[p]        = 1'b0;
            rsp_out_read_enable[p]  = rsp_in_read_enable;
            rsp_out_write_enable[p] = rsp_in_write_enable;
            rsp_out_addr[p]         = rsp_in_addr;
            rsp_out_data[p]         = rsp_in_data;
            rsp_out_id[p]           = rsp_in_id[ID_WIDTH-1:0];
            if (rsp_sel == SEL_WIDTH'(p)) begin
                rsp_hit          = 1'b1;
                rsp_out_valid[p] = rsp_in_valid;
                rsp_in_ready     = rsp_out_ready[p];
            end
        end
    end

    // A response to a nonexistent port is accepted and dropped.
    assert property (@(posedge clk) disable iff (rst) rsp_in_valid |-> rsp_hit)
        else $error("mem_arbiter: response select out of range");

    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (rst) begin
                cnt[p] <= '0;
            end else begin
                if (gnt[p] && req_in_read_enable[p] && !(rsp_out_valid[p] && rsp_out_ready[p])) begin
                    cnt[p] <= cnt[p] + 1'b1;
                end else if (!(gnt[p] && req_in_read_enable[p]) && rsp_out_valid[p] &&
                             rsp_out_ready[p] && cnt[p] != '0) begin
                    cnt[p] <= cnt[p] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        idle = !req_out_valid;
        for (int p = 0; p < PORTS; p++) begin
            if (cnt[p] != '0) begin
                idle = 1'b0;
            end
        end
    end

endmodule
